// File: rtl/hwpe_stream_lane_decoupler.sv
// Per-lane elastic FIFOs behind a stream splitter; absorbs lane-to-lane ready skew.
// Optional combinational fall-through on empty lanes: HWPE_STREAM_LANE_DECOUPLER_FALLTHROUGH_EN.
module hwpe_stream_lane_decoupler #(
    parameter int unsigned NB_LANES   = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic [NB_LANES-1:0]              push_valid_i,
    output logic [NB_LANES-1:0]              push_ready_o,
    input  logic [NB_LANES*DATA_WIDTH-1:0]   push_data_i,
    input  logic [NB_LANES*DATA_WIDTH/8-1:0] push_strb_i,
    output logic [NB_LANES-1:0]              pop_valid_o,
    input  logic [NB_LANES-1:0]              pop_ready_i,
    output logic [NB_LANES*DATA_WIDTH-1:0]   pop_data_o,
    output logic [NB_LANES*DATA_WIDTH/8-1:0] pop_strb_o,
    output logic [NB_LANES-1:0]              empty_o,
    output logic [NB_LANES-1:0]              full_o,
    output logic                             idle_o
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned EW = DATA_WIDTH + SW;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

    for (genvar i = 0; i < NB_LANES; i++) begin : gen_lane
        logic [EW-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] cnt_q;
        logic [EW-1:0] push_word, pop_word;
        logic          empty, full, fwd, push_hs, pop_hs, skip, do_write, do_read;

        assign push_word = {push_strb_i[i*SW +: SW], push_data_i[i*DATA_WIDTH +: DATA_WIDTH]};
        assign empty     = (cnt_q == '0);
        assign full      = (cnt_q == CntFull);

`ifdef HWPE_STREAM_LANE_DECOUPLER_FALLTHROUGH_EN
        // Forwarding is suppressed in reset so outputs stay at their reset values.
        assign fwd = empty & ~rst_i;
`else
        assign fwd = 1'b0;
`endif

        assign pop_valid_o[i]  = ~empty | (fwd & push_valid_i[i]);
        assign pop_word        = fwd ? push_word : mem_q[rptr_q];
        assign push_ready_o[i] = ~full;

        assign push_hs = push_valid_i[i] & ~full;
        assign pop_hs  = pop_valid_o[i] & pop_ready_i[i];
        // A forwarded beat consumed in the same cycle never touches the storage.
        assign skip     = fwd & pop_hs;
        assign do_write = push_hs & ~skip & ~clear_i;
        assign do_read  = pop_hs & ~skip & ~clear_i;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                    mem_q[k] <= '0;
                end
            end else if (clear_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (do_write) begin
                    mem_q[wptr_q] <= push_word;
                    wptr_q        <= wptr_q + AW'(1);
                end
                if (do_read) begin
                    rptr_q <= rptr_q + AW'(1);
                end
                if (do_write && !do_read) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (do_read && !do_write) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end

        assign pop_data_o[i*DATA_WIDTH +: DATA_WIDTH] = pop_word[DATA_WIDTH-1:0];
        assign pop_strb_o[i*SW +: SW]                 = pop_word[EW-1:DATA_WIDTH];
        assign empty_o[i]                             = empty;
        assign full_o[i]                              = full;
    end

    assign idle_o = &empty_o;

endmodule

// File: tb/tb_hwpe_stream_lane_decoupler.sv
// Scoreboard bench for hwpe_stream_lane_decoupler (2 lanes, 32-bit, depth 2).
module tb_hwpe_stream_lane_decoupler;

    localparam int unsigned NB    = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [NB-1:0]  push_valid;
    logic [NB-1:0]  push_ready;
    logic [63:0]    push_data;
    logic [7:0]     push_strb;
    logic [NB-1:0]  pop_valid;
    logic [NB-1:0]  pop_ready;
    logic [63:0]    pop_data;
    logic [7:0]     pop_strb;
    logic [NB-1:0]  empty;
    logic [NB-1:0]  full;
    logic           idle;

    int n_vec = 0;
    int n_err = 0;

    // Expected lane contents, {strb, data} per entry.
    logic [35:0] sb [NB][$];

    hwpe_stream_lane_decoupler #(
        .NB_LANES  (NB),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .push_valid_i(push_valid),
        .push_ready_o(push_ready),
        .push_data_i (push_data),
        .push_strb_i (push_strb),
        .pop_valid_o (pop_valid),
        .pop_ready_i (pop_ready),
        .pop_data_o  (pop_data),
        .pop_strb_o  (pop_strb),
        .empty_o     (empty),
        .full_o      (full),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] mk_strb(input logic [31:0] d, input int l);
        return d[3:0] ^ d[7:4] ^ 4'(l);
    endfunction

    // Entered just after a rising edge; drives one cycle of stimulus, checks, advances model.
    task automatic step(input logic [1:0] pv, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] pr, input logic clr);
        logic [35:0] pw [NB];
        logic [1:0]  e_rdy, e_vld, e_emp, e_full;
        logic [35:0] e_word [NB];
        logic        fwd [NB];
        int          cnt;
        pw[0] = {mk_strb(d0, 0), d0};
        pw[1] = {mk_strb(d1, 1), d1};
        push_valid = pv;
        push_data  = {d1, d0};
        push_strb  = {pw[1][35:32], pw[0][35:32]};
        pop_ready  = pr;
        clear      = clr;
        #2;
        for (int l = 0; l < NB; l++) begin
            cnt       = sb[l].size();
            e_rdy[l]  = (cnt != DEPTH);
            e_emp[l]  = (cnt == 0);
            e_full[l] = (cnt == DEPTH);
`ifdef HWPE_STREAM_LANE_DECOUPLER_FALLTHROUGH_EN
            fwd[l] = (cnt == 0);
`else
            fwd[l] = 1'b0;
`endif
            e_vld[l]  = (cnt != 0) || (fwd[l] && pv[l]);
            e_word[l] = (cnt != 0) ? sb[l][0] : pw[l];
        end
        check_eq("push_ready", 64'(push_ready), 64'(e_rdy));
        check_eq("pop_valid", 64'(pop_valid), 64'(e_vld));
        check_eq("empty", 64'(empty), 64'(e_emp));
        check_eq("full", 64'(full), 64'(e_full));
        check_eq("idle", 64'(idle), 64'(&e_emp));
        for (int l = 0; l < NB; l++) begin
            if (e_vld[l]) begin
                check_eq($sformatf("pop_word%0d", l),
                         64'({pop_strb[l*4 +: 4], pop_data[l*32 +: 32]}), 64'(e_word[l]));
            end
        end
        for (int l = 0; l < NB; l++) begin
            if (clr) begin
                sb[l].delete();
            end else if (!(fwd[l] && pv[l] && pr[l])) begin
                if (e_vld[l] && pr[l]) void'(sb[l].pop_front());
                if (pv[l] && e_rdy[l]) sb[l].push_back(pw[l]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        push_valid = '0;
        push_data  = '0;
        push_strb  = '0;
        pop_ready  = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset held with traffic on the push side.
        push_valid = 2'b11;
        push_data  = {2{32'hA5A5A5A5}};
        push_strb  = 8'hFF;
        pop_ready  = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #2;
            check_eq("rst_pop_valid", 64'(pop_valid), 64'd0);
            check_eq("rst_pop_data", pop_data, 64'd0);
            check_eq("rst_pop_strb", 64'(pop_strb), 64'd0);
            check_eq("rst_push_ready", 64'(push_ready), 64'h3);
            check_eq("rst_idle", 64'(idle), 64'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        step(2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

        // Streaming, both lanes always ready.
        for (int b = 0; b < 16; b++) begin
            step(2'b11, 32'(b), 32'(b + 100), 2'b11, 1'b0);
        end
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

        // Skew: lane 1 stalled while lane 0 flows.
        step(2'b11, 32'h10, 32'h20, 2'b01, 1'b0);
        step(2'b11, 32'h11, 32'h21, 2'b01, 1'b0);
        #2;
        check_eq("skew_full", 64'(full), 64'h2);
        step(2'b11, 32'h12, 32'h22, 2'b01, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        end

        // Full lane with a simultaneous pop: push refused that cycle.
        step(2'b01, 32'h30, 32'h0, 2'b00, 1'b0);
        step(2'b01, 32'h31, 32'h0, 2'b00, 1'b0);
        step(2'b01, 32'hF00D, 32'h0, 2'b01, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

        // Clear with handshakes in flight.
        step(2'b11, 32'h40, 32'h50, 2'b00, 1'b0);
        step(2'b11, 32'h41, 32'h51, 2'b00, 1'b0);
        step(2'b11, 32'h42, 32'h52, 2'b11, 1'b1);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

`ifdef HWPE_STREAM_LANE_DECOUPLER_FALLTHROUGH_EN
        step(2'b01, 32'h1234, 32'h0, 2'b01, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
`endif

        for (int c = 0; c < 80; c++) begin
            step(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
        end
        for (int c = 0; c < 3; c++) begin
            step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_lane_decoupler.md
# hwpe_stream_lane_decoupler

Per-lane elastic buffering stage placed directly downstream of the stream splitter that fans one wide stream into `NB_LANES` narrow lanes. The splitter broadcasts valid and only advances when every lane is ready. This block gives each lane an independent FIFO so that lane-to-lane ready skew (e.g. TCDM grant conflicts on individual store ports) is absorbed instead of stalling the whole wide stream. Each lane is fully independent; there is no cross-lane state.

## Interface
- `NB_LANES`, default 2: number of lanes (≥1).
- `DATA_WIDTH`, default 32: lane data width (multiple of 8); strb width is `DATA_WIDTH/8`.
- `FIFO_DEPTH`, default 2: entries per lane; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `clear_i`  in  1  synchronous flush of all lanes.
- `push_i[NB_LANES-1:0]`  sink  hwpe_stream_intf_stream  input lanes (from splitter).
- `pop_o[NB_LANES-1:0]`  source  hwpe_stream_intf_stream  output lanes (to store ports).
- `empty_o`  out  NB_LANES  lane i holds 0 entries.
- `full_o`  out  NB_LANES  lane i holds FIFO_DEPTH entries.
- `idle_o`  out  1  AND of `empty_o`.

## Operation
- Per lane: storage array of FIFO_DEPTH × {data, strb}, write pointer, read pointer (`$clog2(FIFO_DEPTH)` bits, natural wrap), count (`$clog2(FIFO_DEPTH+1)` bits).
- Push handshake: `push_i[i].valid & push_i[i].ready`; writes mem[wptr], wptr+1, count+1.
- Pop handshake: `pop_o[i].valid & pop_o[i].ready`; rptr+1, count−1.
- Simultaneous push and pop: both pointers advance, count unchanged.
- `push_i[i].ready = (count != FIFO_DEPTH)`: depends on state only, no combinational path from `pop_o[i].ready`. When full, a same-cycle pop does not enable a push.
- `pop_o[i].valid = (count != 0)`; `pop_o[i].data/strb = mem[rptr]`.
- Data and strb pass unmodified; strb is stored, not interpreted.
- `clear_i`: next edge sets pointers and count to 0. Handshakes in the clear cycle are discarded: no write, no count change. Memory contents need not be cleared.
- Reset values: pointers and count 0, memory 0. Hence `pop_o.valid=0`, `pop_o.data=0`, `pop_o.strb=0`, `push_i.ready=1`, `empty_o` all 1, `full_o` all 0, `idle_o=1`. These hold while `rst_i` is high; reset asserted mid-transfer discards all buffered beats.
- Lane state machine, implicit in count: EMPTY (0) → PARTIAL → FULL (FIFO_DEPTH). Push-only increments, pop-only decrements, both or neither hold.

## Timing
- Latency push→pop: 1 cycle. A beat accepted at edge N is valid on `pop_o` after edge N.
- Throughput: 1 beat/cycle/lane sustained when downstream is always ready (count oscillates 0↔1 or holds).
- Full lane: ready low from the edge that makes count=FIFO_DEPTH until the edge after the first pop.
- Splitter upstream advances only when all lanes have space; the wide stream stalls only once some lane lags by FIFO_DEPTH beats.
- Status outputs are registered-state decodes, valid same cycle as count.

## Configuration
- `HWPE_STREAM_LANE_DECOUPLER_FALLTHROUGH_EN` defined:
  - An empty lane forwards `push_i` to `pop_o` combinationally: `pop_o.valid = push_i.valid` and data/strb from `push_i`.
  - If popped in the same cycle, nothing is written and count stays 0 (latency 0).
  - `push_i.ready` is still state-only.
- Undefined: 1-cycle latency as above, no combinational path from push_i to pop_o.

## Test plan
- Reset: hold `rst_i`=1 with push valid → pop valid=0, data=0, ready=1, idle_o=1; after release push 0xA5A5A5A5 → appears next cycle on pop.
- Streaming: NB_LANES=2, DEPTH=2, both pop ready=1, push 16 incrementing beats back-to-back → 16 beats out in order, 1-cycle latency, no bubbles.
- Skew: lane1 pop ready=0 for 3 cycles while lane0 ready → lane1 full after 2 beats, `full_o`=2'b10. Splitter-side ready for lane1 drops; lane1 drains in order once ready returns.
- Full + simultaneous pop: lane full, pop ready=1, push valid=1 → that cycle push not accepted; next cycle count=DEPTH−1 and ready=1.
- Clear mid-traffic: lane holding 2 beats, `clear_i`=1 with push handshake → next cycle empty, pop valid=0, pushed beat lost.
- Fallthrough (macro defined): empty lane, push 0x1234 with pop ready=1 → same-cycle pop data 0x1234, count stays 0.
